muldiv_seq: RTL



---
 rtl/muldiv_seq_pkg.sv | 49 ++++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op codes, FSM states, op-class helpers.
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    logic res;
    case (op)
      MD_MULH, MD_MULHSU, MD_DIV, MD_REM: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    logic res;
    case (op)
      MD_MULH, MD_DIV, MD_REM: res = 1'b1;
      default:                 res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic                is_div_i,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN-1:0]     md_i,
  output logic [2*XLEN-1:0]   acc_o
);

  logic [XLEN:0] sum_s;
  logic [XLEN:0] rem_sh_s;
  logic [XLEN:0] diff_s;

  // acc holds {hi, lo}: product/multiplier for multiply, remainder/dividend-quotient for divide
  always_comb begin
    sum_s    = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, md_i};
    rem_sh_s = acc_i[2*XLEN-1:XLEN-1];
    diff_s   = rem_sh_s - {1'b0, md_i};
    if (is_div_i) begin
      // remainder stays below the divisor, so diff_s[XLEN] is a reliable sign bit
      if (!diff_s[XLEN]) begin
        acc_o = {diff_s[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh_s[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end else begin
      if (acc_i[0]) begin
        acc_o = {sum_s, acc_i[XLEN-1:1]};
      end else begin
        acc_o = {1'b0, acc_i[2*XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer. Optional multiply early-out: define MULDIV_EARLY_OUT_EN.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   md_q, md_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0]   mlr_q, mlr_d;
`endif

  logic              neg_a_s, neg_b_s;
  logic [XLEN-1:0]   abs_a_s, abs_b_s;
  logic              div_zero_s, ovf_s;
  logic [2*XLEN-1:0] step_acc_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s, fix_s;

  assign neg_a_s    = is_signed_a(op_q) & a_q[XLEN-1];
  assign neg_b_s    = is_signed_b(op_q) & b_q[XLEN-1];
  assign abs_a_s    = neg_a_s ? -a_q : a_q;
  assign abs_b_s    = neg_b_s ? -b_q : b_q;
  assign div_zero_s = (b_q == {XLEN{1'b0}});
  assign ovf_s      = is_signed_b(op_q) & is_div(op_q) & (a_q == INT_MIN) & (b_q == {XLEN{1'b1}});

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (is_div(op_q)),
    .acc_i    (acc_q),
    .md_i     (md_q),
    .acc_o    (step_acc_s)
  );

`ifdef MULDIV_EARLY_OUT_EN
  // an early exit leaves cnt_q shifts undone; finish them here
  assign prod_s = acc_q >> cnt_q;
`else
  assign prod_s = acc_q;
`endif
  assign prod_fix_s = neg_q ? -prod_s : prod_s;
  assign quo_fix_s  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix_s  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  // final word selection for the FIX state
  always_comb begin
    case (op_q)
      MD_MUL:                        fix_s = prod_fix_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  fix_s = prod_fix_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               fix_s = quo_fix_s;
      MD_REM, MD_REMU:               fix_s = rem_fix_s;
      default:                       fix_s = {XLEN{1'b0}};
    endcase
  end

  // next-state and datapath register computation
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    md_d     = md_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
`ifdef MULDIV_EARLY_OUT_EN
    mlr_d    = mlr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q && !flush) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = ST_PREP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREP: begin
        cnt_d = CNT_LOAD;
        if (is_div(op_q)) begin
          md_d  = abs_b_s;
          acc_d = {{XLEN{1'b0}}, abs_a_s};
        end else begin
          md_d  = abs_a_s;
          acc_d = {{XLEN{1'b0}}, abs_b_s};
        end
`ifdef MULDIV_EARLY_OUT_EN
        // multiplier bits still to consume after the first iteration
        mlr_d = {1'b0, abs_b_s[XLEN-1:1]};
`endif
        neg_d = is_rem(op_q) ? neg_a_s : (neg_a_s ^ neg_b_s);
        if (is_div(op_q) && div_zero_s) begin
          result_d = op_q[1] ? a_q : {XLEN{1'b1}};
          state_d  = ST_DONE;
        end else if (ovf_s) begin
          result_d = op_q[1] ? {XLEN{1'b0}} : INT_MIN;
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = step_acc_s;
        cnt_d = cnt_q - CNT_ONE;
`ifdef MULDIV_EARLY_OUT_EN
        mlr_d = {1'b0, mlr_q[XLEN-1:1]};
        if ((cnt_q == CNT_ONE) || (!is_div(op_q) && (mlr_q == {XLEN{1'b0}}))) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
`else
        if (cnt_q == CNT_ONE) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
`endif
      end
      ST_FIX: begin
        result_d = fix_s;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // flush wins everywhere and leaves the last delivered result untouched
    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end else begin
      state_d  = state_d;
    end
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // state, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      a_q         <= {XLEN{1'b0}};
      b_q         <= {XLEN{1'b0}};
      md_q        <= {XLEN{1'b0}};
      acc_q       <= {(2*XLEN){1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      neg_q       <= 1'b0;
      result_q    <= {XLEN{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      mlr_q       <= {XLEN{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      md_q        <= md_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef MULDIV_EARLY_OUT_EN
      mlr_q       <= mlr_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule
